// File: rtl/m72_irq_scheduler.sv
// Interrupt scheduler: turns VBLK rising edges and raster-line matches into a
// prioritised CPU interrupt request with vector, completed by an INTA handshake.
module m72_irq_scheduler #(
    parameter logic [7:0]  VEC_VBL  = 8'h20,
    parameter logic [7:0]  VEC_RAST = 8'h22,
    parameter int unsigned HOLDOFF  = 2
) (
    input  logic        CLK_32M,
    input  logic        RESET_N,
    input  logic        CE_PIX,
    input  logic [8:0]  V,
    input  logic        HBLK,
    input  logic        VBLK,
    input  logic [15:0] D,
    input  logic        A0,
    input  logic        LSET,
    input  logic        ESET,
    input  logic        INTA,
    output logic        INTREQ,
    output logic [7:0]  VECTOR,
    output logic [8:0]  RAST_LINE,
    output logic [1:0]  PENDING,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    localparam int unsigned    CW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLDOFF - 1);

    state_e        state_q, state_d;
    logic          sel_q, sel_d;          // 0 = VBL, 1 = RAST
    logic [7:0]    vector_q, vector_d;
    logic [8:0]    line_q, line_d;
    logic [1:0]    en_q, en_d;            // {rast, vbl}
    logic [1:0]    pending_q, pending_d;
    logic          hblk_q, hblk_d;
    logic          vblk_q, vblk_d;
    logic          inta_q;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;

    logic       vbl_ev, rast_ev, inta_edge, ack, withdraw;
    logic [1:0] set_v, en_off, ack_clr, sel_mask;

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            vector_q   <= 8'h00;
            line_q     <= 9'h000;
            en_q       <= 2'b00;
            pending_q  <= 2'b00;
            hblk_q     <= 1'b0;
            vblk_q     <= 1'b0;
            inta_q     <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            vector_q   <= vector_d;
            line_q     <= line_d;
            en_q       <= en_d;
            pending_q  <= pending_d;
            hblk_q     <= hblk_d;
            vblk_q     <= vblk_d;
            inta_q     <= INTA;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Register writes, event detection and pending latches. Compares use the
    // registered line/enables, so a write only takes effect on the next clock.
    always_comb begin
        line_d = line_q;
        if (LSET) begin
            if (A0) line_d[8]   = D[0];
            else    line_d[7:0] = D[7:0];
        end
        en_d   = ESET ? D[1:0] : en_q;
        hblk_d = CE_PIX ? HBLK : hblk_q;
        vblk_d = CE_PIX ? VBLK : vblk_q;

        vbl_ev    = CE_PIX & VBLK & ~vblk_q;
        rast_ev   = CE_PIX & HBLK & ~hblk_q & (V == line_q);
        set_v     = {rast_ev & en_q[1], vbl_ev & en_q[0]};
        en_off    = {2{ESET}} & ~D[1:0];
        inta_edge = INTA & ~inta_q;
        sel_mask  = sel_q ? 2'b10 : 2'b01;
        ack       = (state_q == S_REQ) & inta_edge;
        ack_clr   = ack ? sel_mask : 2'b00;

        // Set wins over a same-cycle clear, which is how events merge into an ack.
        pending_d = (pending_q & ~(ack_clr | en_off)) | set_v;
        withdraw  = (state_q == S_REQ) & ~ack & ((pending_d & sel_mask) == 2'b00);
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        vector_d   = vector_q;
        hold_cnt_d = (state_q == S_HOLD) ? hold_cnt_q + 1'b1 : '0;
        case (state_q)
            S_IDLE: begin
                if (pending_q != 2'b00) begin
                    state_d  = S_REQ;
                    sel_d    = ~pending_q[0];
                    vector_d = pending_q[0] ? VEC_VBL : VEC_RAST;
                end
            end
            S_REQ: begin
                if (ack)           state_d = S_ACK;
                else if (withdraw) state_d = S_HOLD;
            end
            S_ACK:  state_d = S_HOLD;
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        INTREQ    = (state_q == S_REQ);
        VECTOR    = vector_q;
        RAST_LINE = line_q;
        PENDING   = pending_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_m72_irq_scheduler.sv
// Self-checking bench for m72_irq_scheduler: a scoreboard queue of expected
// vectors is pushed when events are driven and popped on each INTREQ rise.
module tb_m72_irq_scheduler;

    localparam int unsigned HOLDOFF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce_pix = 1'b1;
    logic [8:0]  v = 9'h000;
    logic        hblk = 1'b0;
    logic        vblk = 1'b0;
    logic [15:0] d = 16'h0000;
    logic        a0 = 1'b0;
    logic        lset = 1'b0;
    logic        eset = 1'b0;
    logic        inta = 1'b0;
    logic        intreq;
    logic [7:0]  vector;
    logic [8:0]  rast_line;
    logic [1:0]  pending;
    logic [1:0]  dbg_state;

    int         n_tests = 0;
    int         n_fail = 0;
    int         n;
    logic [7:0] exp_q[$];
    logic       intreq_prev = 1'b0;

    m72_irq_scheduler #(
        .VEC_VBL (8'h20),
        .VEC_RAST(8'h22),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .CLK_32M  (clk),
        .RESET_N  (rst_n),
        .CE_PIX   (ce_pix),
        .V        (v),
        .HBLK     (hblk),
        .VBLK     (vblk),
        .D        (d),
        .A0       (a0),
        .LSET     (lset),
        .ESET     (eset),
        .INTA     (inta),
        .INTREQ   (intreq),
        .VECTOR   (vector),
        .RAST_LINE(rast_line),
        .PENDING  (pending),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic eset_write(input logic [1:0] en);
        d    = {14'h0, en};
        eset = 1'b1;
        tick();
        eset = 1'b0;
    endtask

    task automatic lset_write(input logic sel, input logic [7:0] val);
        d    = {8'h00, val};
        a0   = sel;
        lset = 1'b1;
        tick();
        lset = 1'b0;
    endtask

    task automatic wait_intreq(input string tag, output int cnt);
        cnt = 0;
        while (!intreq && cnt < 20) begin
            tick();
            cnt++;
        end
        check_eq(tag, 16'(intreq), 16'd1);
    endtask

    task automatic ack(input string tag);
        inta = 1'b1;
        tick();
        inta = 1'b0;
        check_eq(tag, 16'(intreq), 16'd0);
    endtask

    // Scoreboard: every INTREQ rise must match the oldest expected vector.
    always @(negedge clk) begin
        if (rst_n && intreq && !intreq_prev) begin
            check_eq("req_expected", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0)
                check_eq("vector", 16'(vector), 16'(exp_q.pop_front()));
        end
        intreq_prev = intreq;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_eq("rst_intreq", 16'(intreq), 16'd0);
        check_eq("rst_vector", 16'(vector), 16'h00);
        check_eq("rst_line", 16'(rast_line), 16'h000);
        check_eq("rst_pending", 16'(pending), 16'd0);
        check_eq("rst_state", 16'(dbg_state), 16'd0);

        // VBL only
        eset_write(2'b01);
        vblk = 1'b1;
        exp_q.push_back(8'h20);
        tick();
        vblk = 1'b0;
        check_eq("vbl_pending", 16'(pending), 16'd1);
        check_eq("vbl_not_yet", 16'(intreq), 16'd0);
        tick();
        check_eq("vbl_latency", 16'(intreq), 16'd1);
        ack("vbl_ack");
        check_eq("vbl_ack_pending", 16'(pending), 16'd0);
        for (int i = 0; i < int'(HOLDOFF); i++) begin
            tick();
            check_eq("vbl_holdoff", 16'(intreq), 16'd0);
        end
        tick();
        check_eq("vbl_idle", 16'(dbg_state), 16'd0);

        // Raster line 0x140
        lset_write(1'b0, 8'h40);
        lset_write(1'b1, 8'h01);
        eset_write(2'b10);
        check_eq("rast_line", 16'(rast_line), 16'h140);
        v    = 9'h140;
        hblk = 1'b1;
        exp_q.push_back(8'h22);
        tick();
        hblk = 1'b0;
        wait_intreq("rast_req", n);
        check_eq("rast_latency", 16'(n), 16'd1);
        ack("rast_ack");
        repeat (HOLDOFF + 2) tick();
        v    = 9'h040;
        hblk = 1'b1;
        tick();
        hblk = 1'b0;
        vblk = 1'b1;
        tick();
        vblk = 1'b0;
        repeat (4) tick();
        check_eq("rast_miss_pending", 16'(pending), 16'd0);
        check_eq("rast_miss_intreq", 16'(intreq), 16'd0);

        // Edges without CE_PIX are not events
        eset_write(2'b11);
        ce_pix = 1'b0;
        v      = 9'h140;
        vblk   = 1'b1;
        hblk   = 1'b1;
        tick();
        vblk = 1'b0;
        hblk = 1'b0;
        tick();
        ce_pix = 1'b1;
        repeat (2) tick();
        check_eq("ce_gate_pending", 16'(pending), 16'd0);
        check_eq("ce_gate_intreq", 16'(intreq), 16'd0);

        // Simultaneous events: VBL first, then RAST
        vblk = 1'b1;
        hblk = 1'b1;
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h22);
        tick();
        vblk = 1'b0;
        hblk = 1'b0;
        check_eq("sim_pending", 16'(pending), 16'd3);
        wait_intreq("sim_first", n);
        ack("sim_ack1");
        check_eq("sim_pending_after", 16'(pending), 16'd2);
        wait_intreq("sim_second", n);
        check_eq("sim_gap", 16'(n), 16'(HOLDOFF + 2));

        // A VBL event while serving RAST waits; then withdraw RAST
        vblk = 1'b1;
        exp_q.push_back(8'h20);
        tick();
        vblk = 1'b0;
        check_eq("nopre_vector", 16'(vector), 16'h22);
        check_eq("nopre_intreq", 16'(intreq), 16'd1);
        check_eq("nopre_pending", 16'(pending), 16'd3);
        eset_write(2'b01);
        check_eq("wd_intreq", 16'(intreq), 16'd0);
        check_eq("wd_pending", 16'(pending), 16'd1);
        check_eq("wd_vector", 16'(vector), 16'h22);
        check_eq("wd_state", 16'(dbg_state), 16'd3);
        wait_intreq("wd_next", n);
        check_eq("wd_gap", 16'(n), 16'(HOLDOFF + 1));
        ack("wd_ack");
        repeat (HOLDOFF + 2) tick();
        check_eq("wd_done_pending", 16'(pending), 16'd0);

        // Merge + set-wins: new VBL event on the same edge as the ack
        vblk = 1'b1;
        exp_q.push_back(8'h20);
        tick();
        vblk = 1'b0;
        wait_intreq("mrg_req", n);
        inta = 1'b1;
        vblk = 1'b1;
        exp_q.push_back(8'h20);
        tick();
        inta = 1'b0;
        vblk = 1'b0;
        check_eq("mrg_intreq", 16'(intreq), 16'd0);
        check_eq("mrg_pending", 16'(pending), 16'd1);
        wait_intreq("mrg_second", n);
        check_eq("mrg_gap", 16'(n), 16'(HOLDOFF + 2));
        ack("mrg_ack2");
        repeat (HOLDOFF + 2) tick();
        check_eq("mrg_done_pending", 16'(pending), 16'd0);

        // INTA already high when REQ is entered: no ack until it drops and rises
        inta = 1'b1;
        repeat (2) tick();
        vblk = 1'b1;
        exp_q.push_back(8'h20);
        tick();
        vblk = 1'b0;
        wait_intreq("inta_hi_req", n);
        repeat (3) begin
            tick();
            check_eq("inta_hi_hold", 16'(intreq), 16'd1);
        end
        inta = 1'b0;
        tick();
        check_eq("inta_low_hold", 16'(intreq), 16'd1);
        ack("inta_hi_ack");
        repeat (HOLDOFF + 2) tick();

        // Asynchronous reset while in REQ
        eset_write(2'b11);
        lset_write(1'b0, 8'h55);
        vblk = 1'b1;
        exp_q.push_back(8'h20);
        tick();
        vblk = 1'b0;
        wait_intreq("rst_req", n);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_intreq", 16'(intreq), 16'd0);
        check_eq("arst_vector", 16'(vector), 16'h00);
        check_eq("arst_line", 16'(rast_line), 16'h000);
        check_eq("arst_pending", 16'(pending), 16'd0);
        check_eq("arst_state", 16'(dbg_state), 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        vblk = 1'b1;
        tick();
        vblk = 1'b0;
        repeat (4) tick();
        check_eq("post_rst_pending", 16'(pending), 16'd0);
        check_eq("post_rst_intreq", 16'(intreq), 16'd0);
        eset_write(2'b01);
        vblk = 1'b1;
        exp_q.push_back(8'h20);
        tick();
        vblk = 1'b0;
        wait_intreq("post_rst_req", n);
        ack("post_rst_ack");
        repeat (HOLDOFF + 2) tick();

        check_eq("exp_q_empty", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
